// File: rtl/dma_hold_master_if.sv
// dma_hold_master_if: CPU register window, hold/holdACK handshake and data-memory port of the DMA master
interface dma_hold_master_if;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] dataIn;
  logic        holdACK;
  logic        hold;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;
  logic        busy;
  logic        done;
  logic        irq;
  modport master (input we, addr, dataIn, holdACK, dm_rd, output hold, dm_we, dm_addr, dm_wd, busy, done, irq);
  modport slave (output we, addr, dataIn, holdACK, dm_rd, input hold, dm_we, dm_addr, dm_wd, busy, done, irq);
endinterface

// File: rtl/dma_hold_master.sv
// dma_hold_master: hold/holdACK bus master copying CNT words from SRC to DST in bursts of up to MAX_BURST
module dma_hold_master #(
  parameter int         MAX_BURST = 8,
  parameter logic [4:0] BASE_ADDR = 5'b11000
) (
  input logic           clk,
  input logic           rst,
  dma_hold_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, REQ, RD, WR, REL} st_t;
  localparam int BW = $clog2(MAX_BURST + 1);
  st_t         st_q, st_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d, addr_q, addr_d, wd_q, wd_d;
  logic [BW-1:0] burst_q, burst_d;
  logic        ien_q, ien_d, done_q, done_d;
  logic [4:0]  off;
  logic        win, ctrl;
  assign off  = bus.addr - BASE_ADDR;
  assign win  = bus.we && off < 5'd4;
  assign ctrl = win && off == 5'd3;
  always_comb begin
    st_d    = st_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    ien_d   = ctrl ? bus.dataIn[2] : ien_q;
    done_d  = ctrl && bus.dataIn[1] ? 1'b0 : done_q;
    if (win && st_q == IDLE) begin
      src_d = off == 5'd0 ? {bus.dataIn[31:2], 2'b00} : src_q;
      dst_d = off == 5'd1 ? {bus.dataIn[31:2], 2'b00} : dst_q;
      cnt_d = off == 5'd2 ? bus.dataIn : cnt_q;
    end
    case (st_q)
      IDLE: if (ctrl && bus.dataIn[0]) begin
        done_d  = 1'b1;
        if (cnt_q != 32'd0) begin
          done_d  = 1'b0;
          burst_d = '0;
          st_d    = REQ;
        end
      end
      REQ: st_d = bus.holdACK ? RD : REQ;
      RD:  st_d = bus.holdACK ? WR : REQ;
      WR: if (bus.holdACK) begin
        src_d   = src_q + 32'd4;
        dst_d   = dst_q + 32'd4;
        cnt_d   = cnt_q - 32'd1;
        burst_d = burst_q + 1'b1;
        done_d  = cnt_q == 32'd1 ? 1'b1 : done_d;
        st_d    = cnt_q == 32'd1 || burst_d == BW'(MAX_BURST) ? REL : RD;
      end else begin
        st_d = REQ;
      end
      REL: if (!bus.holdACK) begin
        st_d    = cnt_q == 32'd0 ? IDLE : REQ;
        burst_d = '0;
      end
      default: st_d = IDLE;
    endcase
    // Address and data are registered one cycle ahead so they are stable for the whole RD/WR cycle
    addr_d = st_d == RD ? src_d : st_d == WR ? dst_q : addr_q;
    wd_d   = st_d == WR ? bus.dm_rd : wd_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      ien_q   <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      st_q    <= st_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      ien_q   <= ien_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end
  assign bus.hold    = st_q == REQ || st_q == RD || st_q == WR;
  // A write only lands while the grant is still held this cycle
  assign bus.dm_we   = st_q == WR && bus.holdACK;
  assign bus.dm_addr = addr_q;
  assign bus.dm_wd   = wd_q;
  assign bus.busy    = st_q != IDLE;
  assign bus.done    = done_q;
  assign bus.irq     = done_q & ien_q;
endmodule

// File: tb/tb_dma_hold_master.sv
// tb_dma_hold_master: directed self-checking bench for dma_hold_master with a word memory and CPU grant model
module tb_dma_hold_master;
  localparam logic [4:0] SRC = 5'h18, DST = 5'h19, CNT = 5'h1A, CTRL = 5'h1B;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dma_hold_master_if h();
  dma_hold_master dut (.clk(clk), .rst(rst), .bus(h));
  logic [31:0] mem [0:1023];
  int wr_cnt = 0;
  int grants = 0;
  int fall_wr [$];
  logic hold_prev = 1'b0;
  int tests = 0;
  int fails = 0;
  bit ack_auto = 1'b1;
  assign h.dm_rd = mem[h.dm_addr[11:2]];
  always @(posedge clk) if (h.dm_we) begin
    mem[h.dm_addr[11:2]] = h.dm_wd;
    wr_cnt = wr_cnt + 1;
  end
  always @(negedge clk) begin
    if (h.hold && !hold_prev) grants = grants + 1;
    if (!h.hold && hold_prev) fall_wr.push_back(wr_cnt);
    hold_prev = h.hold;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (ack_auto) h.holdACK = h.hold;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    h.we = 1'b1;
    h.addr = a;
    h.dataIn = d;
    step();
    h.we = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    for (int n = 0; n < 300 && h.busy; n++) step();
    chk({tag, "_idle"}, h.busy, 0);
  endtask
  task automatic wait_we(input string tag, input int target);
    for (int n = 0; n < 100 && !(h.dm_we && wr_cnt == target); n++) step();
    chk({tag, "_we"}, h.dm_we, 1);
  endtask
  initial begin
    int base, g, nf;
    h.we = 1'b0;
    h.addr = '0;
    h.dataIn = '0;
    h.holdACK = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[16+i] = 32'hA0A0_0000 + i;
    for (int i = 0; i < 10; i++) mem[64+i] = 32'h1000_0000 + i;
    step();
    step();
    rst = 1'b0;
    chk("rst_hold", h.hold, 0);
    chk("rst_dm_we", h.dm_we, 0);
    chk("rst_dm_addr", h.dm_addr, 0);
    chk("rst_dm_wd", h.dm_wd, 0);
    chk("rst_busy", h.busy, 0);
    chk("rst_done", h.done, 0);
    chk("rst_irq", h.irq, 0);
    base = wr_cnt;
    wr(SRC, 32'h40);
    wr(DST, 32'h80);
    wr(CNT, 4);
    wr(CTRL, 1);
    chk("basic_busy", h.busy, 1);
    wait_idle("basic");
    for (int i = 0; i < 4; i++) chk($sformatf("basic_mem%0d", i), mem[32+i], 32'hA0A0_0000 + i);
    chk("basic_pulses", wr_cnt - base, 4);
    chk("basic_done", h.done, 1);
    chk("basic_hold", h.hold, 0);
    base = wr_cnt;
    g = grants;
    nf = fall_wr.size();
    wr(SRC, 32'h100);
    wr(DST, 32'h200);
    wr(CNT, 10);
    wr(CTRL, 1);
    wait_idle("burst");
    chk("burst_grants", grants - g, 2);
    chk("burst_falls", fall_wr.size() - nf, 2);
    if (fall_wr.size() - nf == 2) begin
      chk("burst_first", fall_wr[nf] - base, 8);
      chk("burst_second", fall_wr[nf+1] - base, 10);
    end
    for (int i = 0; i < 10; i++) chk($sformatf("burst_mem%0d", i), mem[128+i], 32'h1000_0000 + i);
    base = wr_cnt;
    wr(SRC, 32'h100);
    wr(DST, 32'h300);
    wr(CNT, 5);
    wr(CTRL, 1);
    wait_we("gl", base + 2);
    ack_auto = 1'b0;
    h.holdACK = 1'b0;
    #1;
    chk("gl_no_we", h.dm_we, 0);
    chk("gl_hold_wr", h.hold, 1);
    step();
    chk("gl_hold_req", h.hold, 1);
    chk("gl_cnt_mid", wr_cnt - base, 2);
    ack_auto = 1'b1;
    wait_idle("gl");
    chk("gl_total", wr_cnt - base, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("gl_mem%0d", i), mem[192+i], 32'h1000_0000 + i);
    wr(CTRL, 2);
    chk("clr_done", h.done, 0);
    g = grants;
    wr(CNT, 0);
    wr(CTRL, 1);
    chk("zc_done", h.done, 1);
    chk("zc_busy", h.busy, 0);
    step();
    step();
    chk("zc_nohold", grants - g, 0);
    wr(SRC, 32'h40);
    wr(DST, 32'h380);
    wr(CNT, 2);
    wr(CTRL, 1);
    wr(SRC, 32'h999);
    wait_idle("prot");
    chk("prot_mem0", mem[224], 32'hA0A0_0000);
    chk("prot_mem1", mem[225], 32'hA0A0_0001);
    wr(SRC, 32'h40);
    wr(DST, 32'h3C0);
    wr(CNT, 1);
    wr(CTRL, 5);
    wait_idle("irq");
    chk("irq_done", h.done, 1);
    chk("irq_set", h.irq, 1);
    chk("irq_mem", mem[240], 32'hA0A0_0000);
    wr(CTRL, 6);
    chk("irq_clr_done", h.done, 0);
    chk("irq_clr", h.irq, 0);
    wr(DST, 32'h3C4);
    wr(CNT, 1);
    wr(CTRL, 5);
    wait_we("same", wr_cnt);
    wr(CTRL, 6);
    chk("same_done", h.done, 1);
    chk("same_irq", h.irq, 1);
    wait_idle("same");
    chk("same_mem", mem[241], 32'hA0A0_0001);
    wr(SRC, 32'h40);
    wr(DST, 32'h300);
    wr(CNT, 4);
    wr(CTRL, 1);
    wait_we("mr", wr_cnt);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_hold", h.hold, 0);
    chk("mr_busy", h.busy, 0);
    chk("mr_done", h.done, 0);
    chk("mr_dm_we", h.dm_we, 0);
    chk("mr_dm_addr", h.dm_addr, 0);
    chk("mr_dm_wd", h.dm_wd, 0);
    g = grants;
    wr(CTRL, 1);
    chk("mr_cnt_zero", h.done, 1);
    chk("mr_irq", h.irq, 0);
    step();
    chk("mr_nohold", grants - g, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dma_hold_master.md
Name: dma_hold_master

Overview:
- Bus-master block that copies a block of words between data-memory addresses on behalf of the CPU.
- Acts as the initiator side of the processor's hold/holdACK handshake. It raises hold, waits for holdACK, and only then drives the data-memory port.
- The CPU programs it through a small register window, using the same we/addr/dataIn style as the timer. Completion is reported via a sticky done flag and an optional interrupt line.

Parameters:
- MAX_BURST, 8: maximum words moved per hold grant. After this many words, hold is released and re-requested so the CPU can make progress.
- BASE_ADDR, 5'b11000: register-window base. SRC = BASE+0, DST = BASE+1, CNT = BASE+2, CTRL = BASE+3.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-high.
- we, input, 1: CPU register write strobe.
- addr, input, 5: CPU register select.
- dataIn, input, 32: CPU write data.
- holdACK, input, 1: CPU grant of the bus.
- hold, output, 1: bus request to the CPU.
- dm_we, output, 1: data-memory write enable.
- dm_addr, output, 32: data-memory byte address.
- dm_wd, output, 32: data-memory write data.
- dm_rd, input, 32: data-memory read data. This is combinational from dm_addr.
- busy, output, 1: transfer in progress (state != IDLE).
- done, output, 1: sticky completion flag.
- irq, output, 1: equals done & ien.

Behaviour:
- Reset: on any posedge clk with rst=1, every register clears and the FSM enters IDLE.
  - Outputs after reset: hold=0, dm_we=0, dm_addr=0, dm_wd=0, busy=0, done=0, irq=0.
  - Registers cleared: src, dst, cnt, burst counter, ien, data buffer.
  - rst takes priority over every other event.
- Register writes (we=1, addr in window):
  - SRC, DST and CNT load dataIn. SRC and DST have bits [1:0] forced to 0.
  - CTRL bits: bit0 = start, bit1 = clear done, bit2 = ien. ien is stored; start and clear-done are one-cycle actions.
  - While busy=1, writes to SRC, DST and CNT are ignored. CTRL writes update ien and clear-done only; start is ignored.
- FSM states: IDLE, REQ, RD, WR, REL.
  - IDLE: hold=0, dm_we=0.
    - start with cnt!=0: done<=0, burst<=0, go to REQ.
    - start with cnt==0: done<=1, stay in IDLE. hold is never raised.
  - REQ: hold=1. When holdACK=1, go to RD. There is no timeout.
  - RD: dm_addr=src, dm_we=0. At the clock edge, buf<=dm_rd and the FSM goes to WR.
  - WR: dm_addr=dst, dm_wd=buf, dm_we=1. At the clock edge:
    - src+=4, dst+=4 (32-bit wrap modulo 2^32), cnt-=1, burst+=1.
    - If cnt becomes 0, done<=1 and go to REL.
    - Else if burst reaches MAX_BURST, go to REL.
    - Else go to RD.
  - REL: hold=0, dm_we=0. Wait for holdACK=0.
    - Then go to IDLE if cnt==0.
    - Otherwise burst<=0 and go to REQ.
- Grant loss: if holdACK=0 while in RD or WR, dm_we is forced to 0 that cycle. The current word is not counted, pointers are unchanged, and the FSM returns to REQ (hold stays 1).
- Throughput: 2 cycles per word while granted. Grant-to-first-write latency is 2 cycles (REQ→RD, RD→WR).
- In any state other than RD and WR, dm_addr and dm_wd hold their last values and dm_we=0.
- Memory model: the memory writes on posedge when dm_we=1, and reads combinationally.
- Simultaneous events:
  - A CTRL write with clear-done in the same cycle that WR sets done: the set wins.
  - start together with clear-done in IDLE: start semantics apply.

Test Plan:
- Basic copy: mem[0x40..0x4C] = {A,B,C,D}; SRC=0x40, DST=0x80, CNT=4, CTRL=1; holdACK follows hold after 1 cycle → mem[0x80..0x8C]={A,B,C,D}; exactly 4 dm_we pulses; done=1; hold drops; busy=0 once holdACK drops.
- Burst split: CNT=10, MAX_BURST=8 → two hold grants, with 8 then 2 writes; hold is low ≥1 cycle between grants; 10 words copied in order.
- Grant loss: deassert holdACK during the 3rd WR → no write that cycle, hold remains 1; after holdACK reasserts, word 3 is rewritten correctly; the total number of successful writes equals CNT.
- Zero count and busy protection: CNT=0, start → done=1 next cycle, hold never 1. Then run CNT=2 and write SRC=0x999 mid-transfer → write ignored, copy uses the original SRC.
- Interrupt and clear: ien=1, transfer completes → irq=1. CTRL=0x6 → done=0 and irq=0 next cycle. Same-cycle completion with clear → done=1.
- Reset mid-transfer: rst pulsed in WR → next cycle hold=0, busy=0, done=0, src/dst/cnt=0, no dm_we.
